pong_pixel_gen: RTL
===================

# pong_pixel_gen

Pixel-generation datapath directly downstream of the game control FSM. Consumes the 2-bit `draw_state` selector and walks the pixels of the selected object: left paddle, right paddle or ball. Emits one registered `(x, y, colour, plot)` per clock to the VGA adapter's write port, using object positions snapshotted at the start of each draw. Pixel counts match the control FSM's draw windows: 40 per paddle, 16 per ball.

## Interface
- `PADDLE_W`, 4: paddle width in pixels
- `PADDLE_H`, 10: paddle height in pixels
- `BALL_SIZE`, 4: ball edge length in pixels
- `L_PADDLE_X`, 8: fixed left-paddle column
- `R_PADDLE_X`, 148: fixed right-paddle column
- `SCREEN_W`, 160: visible columns
- `SCREEN_H`, 120: visible rows

Ports:
- `clk` input 1: clock
- `reset` input 1: reset, asynchronous, active-low
- `draw_state` input 2: 00 none, 01 left paddle, 11 right paddle, 10 ball
- `l_paddle_y` input 7: left paddle top row
- `r_paddle_y` input 7: right paddle top row
- `ball_x` input 8: ball left column
- `ball_y` input 7: ball top row
- `x` output 8: pixel column
- `y` output 7: pixel row
- `colour` output 3: pixel colour
- `plot` output 1: write enable to the VGA adapter
- `obj_done` output 1: one-cycle pulse after an object's last pixel

## Operation
- FSM states: IDLE, DRAW, DONE. Internal registers:
  - `sel` (2 b)
  - base registers `bx` (8 b) and `by` (7 b)
  - offset counters `dx` and `dy`, wide enough for the largest dimension
- IDLE, or DONE with `draw_state` ≠ `sel`, on `draw_state` ≠ 00:
  - latch `sel`
  - latch base: (`L_PADDLE_X`, `l_paddle_y`), (`R_PADDLE_X`, `r_paddle_y`) or (`ball_x`, `ball_y`)
  - `dx` = `dy` = 0
  - go to DRAW
- DRAW emits one pixel per cycle at (`bx`+`dx`, `by`+`dy`), in row-major order: `dx` increments first, wraps at W−1, then `dy` increments.
  - Object size W×H is `PADDLE_W`×`PADDLE_H` for paddles and `BALL_SIZE`² for the ball.
- After pixel (W−1, H−1): go to DONE, and pulse `obj_done` with `plot` = 0.
- DONE holds while `draw_state` == `sel`.
  - 00 → IDLE.
  - A different non-zero value restarts directly.
- In DRAW, `draw_state` ≠ `sel` aborts: `plot` = 0 next edge, no `obj_done`. It then goes to IDLE if 00, otherwise restarts with the new selection.
- Colour: left paddle 3'b100, right paddle 3'b001, ball 3'b111.
- Position inputs are sampled only at the latch edge. Changes during DRAW are ignored.
- Coordinate sums are computed at 9 b (x) and 8 b (y) before bounds handling (see Configuration).

## Timing
- All outputs registered. Reset values: `x` = 0, `y` = 0, `colour` = 0, `plot` = 0, `obj_done` = 0, FSM = IDLE, `sel` = 00.
- Latency: `draw_state` sampled non-zero at edge N, so pixel 0 is valid after edge N+1.
- Pixel k is valid after edge N+1+k.
- `obj_done` = 1 after edge N+1+W·H, for exactly one cycle.
- Paddle: 40 `plot` cycles. Ball: 16 `plot` cycles. No gaps.
- Async reset asserted mid-draw clears all outputs immediately. No pixel is emitted until a fresh selection is sampled after reset releases.
- `plot` is never high in IDLE or DONE.

## Configuration
- `PIXEL_CLIP_EN` defined:
  - pixels with column ≥ `SCREEN_W` or row ≥ `SCREEN_H` still consume their cycle
  - `plot` = 0 for those pixels; `x`/`y` carry the truncated sum
  - `obj_done` timing unchanged
- Undefined: coordinates wrap modulo 2^8 / 2^7, and `plot` = 1 for every pixel.

## Test plan
- Left paddle, `l_paddle_y` = 20, `draw_state` 00→01 and held:
  - 40 consecutive `plot` cycles, colour 3'b100
  - first pixel (8,20), 5th pixel (8,21), last (11,29)
  - `obj_done` one cycle later, then `plot` = 0 while 01 is held
- `PIXEL_CLIP_EN` defined, ball at (158,50), `draw_state` = 10:
  - 16 pixel cycles; `plot` = 1 only for x ∈ {158,159}, giving 8 plotted pixels
  - `obj_done` after the 16th cycle
- Right paddle, `r_paddle_y` = 60, `draw_state` = 11; change `r_paddle_y` to 90 after 5 pixels:
  - all 40 pixels at x 148–151, rows 60–69 (snapshot held)
- `draw_state` 01 for 10 cycles, then 11 with no 00 between:
  - left draw aborts with no `obj_done`
  - right paddle restarts at pixel (148, `r_paddle_y`) on the following cycle
- Reset driven low during ball pixel 7:
  - `plot`, `x`, `y`, `colour`, `obj_done` are 0 before the next clock edge
- After reset release with `draw_state` = 10:
  - a full 16-pixel ball draw from pixel 0

Source files
------------

// File: rtl/pong_pixel_gen_if.sv
// Bus between the game control FSM (master) and the pixel generator (slave):
// object selector and positions in, one registered VGA write per clock out.
interface pong_pixel_gen_if;
  logic [1:0] draw_state;
  logic [6:0] l_paddle_y;
  logic [6:0] r_paddle_y;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       obj_done;

  modport master (
    output draw_state, l_paddle_y, r_paddle_y, ball_x, ball_y,
    input  x, y, colour, plot, obj_done
  );

  modport slave (
    input  draw_state, l_paddle_y, r_paddle_y, ball_x, ball_y,
    output x, y, colour, plot, obj_done
  );
endinterface

// File: rtl/pong_pixel_gen.sv
// Walks the pixels of the selected pong object (paddle or ball) row-major and
// emits one registered VGA write per clock. Define PIXEL_CLIP_EN to drop plot off-screen.
module pong_pixel_gen #(
  parameter int PADDLE_W   = 4,
  parameter int PADDLE_H   = 10,
  parameter int BALL_SIZE  = 4,
  parameter int L_PADDLE_X = 8,
  parameter int R_PADDLE_X = 148,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input logic             clk,
  input logic             reset,
  pong_pixel_gen_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LEFT = 2'b01;
  localparam logic [1:0] SEL_RGHT = 2'b11;

  localparam int MAXD_PW = (PADDLE_W > PADDLE_H) ? PADDLE_W : PADDLE_H;
  localparam int MAXD    = (MAXD_PW > BALL_SIZE) ? MAXD_PW : BALL_SIZE;
  localparam int CW      = (MAXD > 1) ? $clog2(MAXD) : 1;

  logic [1:0]    state, sel;
  logic [7:0]    bx;
  logic [6:0]    by;
  logic [CW-1:0] dx, dy;
  logic          fin;

  logic [CW-1:0] w_m1, h_m1;
  logic [2:0]    obj_col;
  logic [7:0]    nbx;
  logic [6:0]    nby;
  logic          restart;
  logic          pix_ok;

  // A fresh non-zero selection starts a draw from IDLE, or preempts DRAW/DONE.
  assign restart = (bus.draw_state != SEL_NONE) &&
                   ((state == IDLE) || (bus.draw_state != sel));

  always_comb begin
    w_m1    = CW'(PADDLE_W - 1);
    h_m1    = CW'(PADDLE_H - 1);
    obj_col = 3'b100;
    case (sel)
      SEL_LEFT: obj_col = 3'b100;
      SEL_RGHT: obj_col = 3'b001;
      default: begin
        w_m1    = CW'(BALL_SIZE - 1);
        h_m1    = CW'(BALL_SIZE - 1);
        obj_col = 3'b111;
      end
    endcase
  end

  always_comb begin
    nbx = bus.ball_x;
    nby = bus.ball_y;
    case (bus.draw_state)
      SEL_LEFT: begin nbx = 8'(L_PADDLE_X); nby = bus.l_paddle_y; end
      SEL_RGHT: begin nbx = 8'(R_PADDLE_X); nby = bus.r_paddle_y; end
      default:  ;
    endcase
  end

`ifdef PIXEL_CLIP_EN
  // Full-width sums so an off-screen pixel is detected before truncation.
  logic [8:0] sx;
  logic [7:0] sy;
  assign sx     = {1'b0, bx} + 9'(dx);
  assign sy     = {1'b0, by} + 8'(dy);
  assign pix_ok = (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H));
`else
  logic [7:0] sx;
  logic [6:0] sy;
  assign sx     = bx + 8'(dx);
  assign sy     = by + 7'(dy);
  assign pix_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sel          <= SEL_NONE;
      bx           <= '0;
      by           <= '0;
      dx           <= '0;
      dy           <= '0;
      fin          <= 1'b0;
      bus.x        <= '0;
      bus.y        <= '0;
      bus.colour   <= '0;
      bus.plot     <= 1'b0;
      bus.obj_done <= 1'b0;
    end else begin
      bus.plot     <= 1'b0;
      bus.obj_done <= 1'b0;
      if (restart) begin
        sel   <= bus.draw_state;
        bx    <= nbx;
        by    <= nby;
        dx    <= '0;
        dy    <= '0;
        fin   <= 1'b0;
        state <= DRAW;
      end else begin
        case (state)
          DRAW: begin
            if (bus.draw_state != sel) begin
              state <= IDLE;
              fin   <= 1'b0;
            end else if (fin) begin
              // Last pixel went out on the previous edge; this is the done beat.
              bus.obj_done <= 1'b1;
              fin          <= 1'b0;
              state        <= DONE;
            end else begin
              bus.x      <= sx[7:0];
              bus.y      <= sy[6:0];
              bus.colour <= obj_col;
              bus.plot   <= pix_ok;
              if (dx == w_m1) begin
                dx <= '0;
                if (dy == h_m1) fin <= 1'b1;
                else            dy  <= dy + CW'(1);
              end else begin
                dx <= dx + CW'(1);
              end
            end
          end
          DONE: if (bus.draw_state == SEL_NONE) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
